mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/mem_resp_ram.sv | 20 ++
 rtl/mem_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-side responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          WAIT_STATES_DEFAULT = 2;
  localparam logic [15:0] WPROT_LIMIT         = 16'h0040;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port 16-bit word storage: synchronous write, asynchronous read, no reset.
module mem_resp_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states; one-cycle MemReady/MemErr response.
// Optional build macro MEM_RESP_WPROT_EN makes addresses below WPROT_LIMIT read-only.
//
// state  | meaning
// S_IDLE | sample strobes, latch request
// S_WAIT | count down inserted wait states
// S_RESP | MemReady pulse, write commits at exit edge
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int ADDR_BITS   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] MemoryAddress,
  input  logic [15:0] MemoryIn,
  input  logic        C_MRead,
  input  logic        C_MWrite,
  output logic [15:0] MemoryOut,
  output logic        MemReady,
  output logic        MemErr
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q, data_q;
  logic        rd_q, wr_q;

  logic [15:0] cur_addr;
  logic        cur_rd, cur_wr, cur_oor, cur_prot, cur_err;
  logic        capture, load_out, ram_we;
  logic [15:0] ram_rdata;

  assign capture = (state_q == S_IDLE) && (C_MRead || C_MWrite);

  // In IDLE the live inputs are the request (needed for the zero-wait path);
  // everywhere else the latched copy is authoritative.
  always_comb begin
    cur_addr = addr_q;
    cur_rd   = rd_q;
    cur_wr   = wr_q;
    if (state_q == S_IDLE) begin
      cur_addr = MemoryAddress;
      cur_rd   = C_MRead;
      cur_wr   = C_MWrite;
    end
  end

  assign cur_oor = (cur_addr >> ADDR_BITS) != 16'h0000;

`ifdef MEM_RESP_WPROT_EN
  assign cur_prot = cur_wr && (cur_addr < WPROT_LIMIT);
`else
  assign cur_prot = 1'b0;
`endif

  assign cur_err = (cur_rd && cur_wr) || cur_oor || cur_prot;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (capture) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q <= 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_out = (state_d == S_RESP) && (state_q != S_RESP) && cur_rd && !cur_wr;
  assign ram_we   = (state_q == S_RESP) && wr_q && !cur_err;
  assign MemReady = (state_q == S_RESP);
  assign MemErr   = MemReady && cur_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      MemoryOut <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q  <= 4'(WAIT_STATES);
        addr_q <= MemoryAddress;
        data_q <= MemoryIn;
        rd_q   <= C_MRead;
        wr_q   <= C_MWrite;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (load_out) MemoryOut <= cur_oor ? 16'h0000 : ram_rdata;
    end
  end

  mem_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (cur_addr[ADDR_BITS-1:0]),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

endmodule
